// File: rtl/tcam_pkg.sv
// Shared constants, per-group match record and saturating-increment helper for the TCAM encoder.
// With TCAM_MULTI_MATCH_EN defined, the group record also carries a two-or-more flag.
package tcam_pkg;
  localparam int GRP_W     = 8;
  localparam int GRP_IDX_W = 3;

  typedef struct packed {
    logic                 hit;
    logic [GRP_IDX_W-1:0] idx;
`ifdef TCAM_MULTI_MATCH_EN
    logic                 multi;
`endif
  } grp_rec_t;

  // Counters are at most 64 bits wide; callers pass their own all-ones ceiling.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] vmax);
    return (v == vmax) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit lowest-set-bit encoder; bit 0 has the highest priority.
// With TCAM_MULTI_MATCH_EN defined, also flags two or more set bits.
module prio_enc8
  import tcam_pkg::*;
(
  input  logic [GRP_W-1:0]     vec,
  output logic                 hit,
  output logic [GRP_IDX_W-1:0] idx
`ifdef TCAM_MULTI_MATCH_EN
  ,
  output logic                 multi
`endif
);
  always_comb begin
    idx = '0;
    for (int i = GRP_W - 1; i >= 0; i--)
      if (vec[i]) idx = GRP_IDX_W'(i);
  end

  assign hit = |vec;

`ifdef TCAM_MULTI_MATCH_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(vec & (vec - GRP_W'(1)));
`endif
endmodule

// File: rtl/tcam_match_encoder.sv
// Two-stage priority encoder behind the TCAM array, with saturating lookup/hit statistics.
// Optional macro TCAM_MULTI_MATCH_EN adds the multi output and multi_cnt counter.
module tcam_match_encoder
  import tcam_pkg::*;
#(
  parameter int D  = 64,
  parameter int AW = $clog2(D),
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [D-1:0]  match,
  input  logic          match_valid,
  output logic          match_ready,
  output logic [AW-1:0] addr,
  output logic          hit,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          stat_clr,
  output logic [CW-1:0] lookup_cnt,
  output logic [CW-1:0] hit_cnt
`ifdef TCAM_MULTI_MATCH_EN
  ,
  output logic          multi,
  output logic [CW-1:0] multi_cnt
`endif
);
  localparam int G      = D / GRP_W;
  localparam int GW     = (G > 1) ? $clog2(G) : 1;
  localparam int STAGES = 2;
  localparam logic [63:0] CMAX = (64'd1 << CW) - 64'd1;

  logic                 advance, xfer;
  logic [STAGES:1]      vld_pipe;
  grp_rec_t [G-1:0]     grp_d, grp_q;
  logic [G-1:0]         grp_hits;
  logic [GW-1:0]        sel_g;
  logic [GRP_IDX_W-1:0] sel_idx;
  logic                 s2_hit;
  logic [AW-1:0]        addr_d;

  // Whole pipeline moves in lockstep; the input is ready exactly when it moves.
  assign advance     = ~vld_pipe[STAGES] | out_ready;
  assign match_ready = advance;
  assign out_valid   = vld_pipe[STAGES];
  assign xfer        = out_valid & out_ready;

  for (genvar g = 0; g < G; g++) begin : g_lane
    logic                 l_hit;
    logic [GRP_IDX_W-1:0] l_idx;
`ifdef TCAM_MULTI_MATCH_EN
    logic                 l_multi;
    prio_enc8 u_enc (.vec(match[g*GRP_W +: GRP_W]), .hit(l_hit), .idx(l_idx), .multi(l_multi));
    assign grp_d[g].multi = l_multi;
`else
    prio_enc8 u_enc (.vec(match[g*GRP_W +: GRP_W]), .hit(l_hit), .idx(l_idx));
`endif
    assign grp_d[g].hit = l_hit;
    assign grp_d[g].idx = l_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      grp_q    <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], match_valid};
      grp_q    <= grp_d;
    end
  end

`ifdef TCAM_MULTI_MATCH_EN
  logic [G-1:0] grp_multis;
  logic         grp_many, multi_d;
`endif

  always_comb begin
    grp_hits = '0;
`ifdef TCAM_MULTI_MATCH_EN
    grp_multis = '0;
`endif
    for (int g = 0; g < G; g++) begin
      grp_hits[g] = grp_q[g].hit;
`ifdef TCAM_MULTI_MATCH_EN
      grp_multis[g] = grp_q[g].multi;
`endif
    end
  end

  // Group-level selection reuses the 8-bit encoder when there are exactly eight groups.
  if (G == GRP_W) begin : g_s2_enc
    logic [GRP_IDX_W-1:0] gi;
`ifdef TCAM_MULTI_MATCH_EN
    prio_enc8 u_enc (.vec(grp_hits), .hit(s2_hit), .idx(gi), .multi(grp_many));
`else
    prio_enc8 u_enc (.vec(grp_hits), .hit(s2_hit), .idx(gi));
`endif
    assign sel_g = GW'(gi);
  end else begin : g_s2_loop
    always_comb begin
      sel_g = '0;
      for (int g = G - 1; g >= 0; g--)
        if (grp_hits[g]) sel_g = GW'(g);
    end
    assign s2_hit = |grp_hits;
`ifdef TCAM_MULTI_MATCH_EN
    assign grp_many = |(grp_hits & (grp_hits - G'(1)));
`endif
  end

  assign sel_idx = grp_q[sel_g].idx;
  assign addr_d  = s2_hit ? AW'({sel_g, sel_idx}) : '0;
`ifdef TCAM_MULTI_MATCH_EN
  assign multi_d = grp_many | (|grp_multis);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      hit  <= 1'b0;
`ifdef TCAM_MULTI_MATCH_EN
      multi <= 1'b0;
`endif
    end else if (advance) begin
      addr <= addr_d;
      hit  <= s2_hit;
`ifdef TCAM_MULTI_MATCH_EN
      multi <= multi_d;
`endif
    end
  end

  // Clear beats a coincident transfer.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      lookup_cnt <= '0;
      hit_cnt    <= '0;
`ifdef TCAM_MULTI_MATCH_EN
      multi_cnt  <= '0;
`endif
    end else if (xfer) begin
      lookup_cnt <= CW'(sat_inc(64'(lookup_cnt), CMAX));
      if (hit) hit_cnt <= CW'(sat_inc(64'(hit_cnt), CMAX));
`ifdef TCAM_MULTI_MATCH_EN
      if (multi) multi_cnt <= CW'(sat_inc(64'(multi_cnt), CMAX));
`endif
    end
  end
endmodule

// File: tb/tb_tcam_match_encoder.sv
// Directed bench for tcam_match_encoder: scoreboard of expected results plus counter model.
module tb_tcam_match_encoder;
  localparam int D = 64, AW = 6, CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [D-1:0]  match = '0;
  logic          match_valid = 1'b0;
  logic          match_ready;
  logic [AW-1:0] addr;
  logic          hit;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          stat_clr = 1'b0;
  logic [CW-1:0] lookup_cnt, hit_cnt;
`ifdef TCAM_MULTI_MATCH_EN
  logic          multi;
  logic [CW-1:0] multi_cnt;
`endif

  tcam_match_encoder #(.D(D), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .match(match), .match_valid(match_valid),
    .match_ready(match_ready), .addr(addr), .hit(hit), .out_valid(out_valid),
    .out_ready(out_ready), .stat_clr(stat_clr), .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
`ifdef TCAM_MULTI_MATCH_EN
    , .multi(multi), .multi_cnt(multi_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          hit;
    logic          multi;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            checks = 0, errors = 0, n_out = 0;
  bit            chk_en = 1'b0;
  logic [CW-1:0] m_lookup = '0, m_hit = '0, m_multi = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [D-1:0] v);
    exp_t e;
    int   n = 0;
    e.addr = '0;
    for (int i = 0; i < D; i++)
      if (v[i]) begin
        if (n == 0) e.addr = AW'(i);
        n++;
      end
    e.hit   = (n != 0);
    e.multi = (n > 1);
    return e;
  endfunction

  function automatic logic [CW-1:0] sinc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Scoreboard and counter model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("lookup_cnt", 64'(lookup_cnt), 64'(m_lookup));
      check("hit_cnt", 64'(hit_cnt), 64'(m_hit));
`ifdef TCAM_MULTI_MATCH_EN
      check("multi_cnt", 64'(multi_cnt), 64'(m_multi));
`endif
    end
    if (reset) begin
      q.delete();
      m_lookup = '0; m_hit = '0; m_multi = '0;
    end else begin
      if (out_valid && out_ready) begin
        check("out_has_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          n_out++;
          check("sb_addr", 64'(addr), 64'(mon_e.addr));
          check("sb_hit", 64'(hit), 64'(mon_e.hit));
`ifdef TCAM_MULTI_MATCH_EN
          check("sb_multi", 64'(multi), 64'(mon_e.multi));
`endif
          if (!stat_clr) begin
            m_lookup = sinc(m_lookup);
            if (mon_e.hit) m_hit = sinc(m_hit);
            if (mon_e.multi) m_multi = sinc(m_multi);
          end
        end
      end
      if (stat_clr) begin
        m_lookup = '0; m_hit = '0; m_multi = '0;
      end
      if (match_valid && match_ready) q.push_back(model(match));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [D-1:0] v);
    bit ok = 1'b0;
    match = v; match_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = match_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 64'(match_ready), 64'd1);
    match_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin step(); k++; end
    check("drain_empty", 64'(q.size()), 64'd0);
    step();
  endtask

  task automatic lookup1(input logic [D-1:0] v, input logic [AW-1:0] ea, input logic eh);
    send(v);
    check("lat_not_early", 64'(out_valid), 64'd0);
    step();
    check("lat_valid", 64'(out_valid), 64'd1);
    check("addr", 64'(addr), 64'(ea));
    check("hit", 64'(hit), 64'(eh));
    step();
  endtask

  initial begin
    int base;
    logic [D-1:0] v;
    repeat (3) step();
    chk_en = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_hit", 64'(hit), 64'd0);
    check("rst_match_ready", 64'(match_ready), 64'd1);
    reset = 1'b0;
    step();

    lookup1(64'h0000_0000_0000_0100, 6'd8, 1'b1);
    check("cnt1_lookup", 64'(lookup_cnt), 64'd1);
    check("cnt1_hit", 64'(hit_cnt), 64'd1);
    send(64'h8000_0000_0001_0010);
    step();
    check("prio_addr", 64'(addr), 64'd4);
    check("prio_hit", 64'(hit), 64'd1);
`ifdef TCAM_MULTI_MATCH_EN
    check("prio_multi", 64'(multi), 64'd1);
`endif
    step();
    lookup1(64'h0, 6'd0, 1'b0);
    lookup1(64'h8000_0000_0000_0000, 6'd63, 1'b1);
    lookup1(64'h1, 6'd0, 1'b1);
    check("cnt5_lookup", 64'(lookup_cnt), 64'd5);
    check("cnt5_hit", 64'(hit_cnt), 64'd4);

    // Backpressure: four back-to-back lookups, 5-cycle stall after first result.
    base = n_out;
    out_ready = 1'b0;
    send(64'h2);
    send(64'h4);
    match = 64'h8; match_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", 64'(match_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_addr", 64'(addr), 64'd1);
      step();
    end
    out_ready = 1'b1;
    send(64'h8);
    send(64'h10);
    drain();
    check("bp_count", 64'(n_out - base), 64'd4);

    // Clear coincident with a transfer.
    send(64'h2);
    step();
    check("clr_xfer_valid", 64'(out_valid & out_ready), 64'd1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_lookup", 64'(lookup_cnt), 64'd0);
    check("clr_hit", 64'(hit_cnt), 64'd0);

    // Saturation with the 4-bit counters.
    for (int i = 0; i < 20; i++) begin
      v = {$urandom, $urandom};
      if (i % 5 == 0) v = '0;
      else if (i % 3 == 0) v = 64'd1 << $urandom_range(63, 0);
      else if (v == '0) v = 64'h1;
      send(v);
    end
    drain();
    check("sat_lookup", 64'(lookup_cnt), 64'd15);
    check("sat_hit", 64'(hit_cnt), 64'd15);

    // Reset with two results in flight.
    send(64'h10);
    send(64'h20);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    step();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_lookup", 64'(lookup_cnt), 64'd0);
    check("mid_rst_hit", 64'(hit_cnt), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", 64'(out_valid), 64'd0);
      step();
    end
    check("post_rst_queue", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
